// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 data-memory responder.
// Contents:
//   WORD_W        - data word width (64)
//   STAT_*        - Y86 status codes returned on rsp_stat
//   dmem_state_t  - responder FSM state encoding
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage array with a single 8-byte little-endian port.
// The write is synchronous; the read is combinational, and the caller
// registers it. The array has no reset, so its contents survive one.
// Ports:
//   clk    - rising-edge clock
//   we     - write 8 bytes at addr..addr+7
//   addr   - byte address of the least significant byte
//   wdata  - store data, byte 0 goes to addr
//   rdata  - bytes addr..addr+7, byte 0 from addr
// The caller guarantees addr+7 < DEPTH_BYTES whenever the port is used.
module dmem_byte_array
    import y86_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[addr + AW'(i)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Y86 data-memory responder: accepts one 8-byte load or store, performs it
// LATENCY cycles later, and holds the response until the processor takes it.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 = store, 0 = load
//   req_addr, req_wdata   - byte address and little-endian store data
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata, rsp_stat   - load data (0 for stores/errors), Y86 status
// Build option:
//   DMEM_ALIGN_CHECK_EN   - when defined, addresses with addr[2:0] != 0
//                           return ADR instead of being performed.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a request
// ST_WAIT | request captured, latency counter running down
// ST_RESP | access performed, response held until rsp_ready
module dmem_responder
    import y86_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic [2:0]        rsp_stat
);

    localparam int         AW       = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_t       state, state_nxt;
    logic [3:0]        cnt;
    logic              cap_write;
    logic [WORD_W-1:0] cap_addr, cap_wdata;

    logic              accept, perform, addr_err;
    logic              acc_write;
    logic [WORD_W-1:0] acc_addr, acc_wdata, mem_rdata;
    logic [WORD_W:0]   end_addr;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        perform   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    perform   = (LATENCY == 1);
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = ST_RESP;
                    perform   = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= CNT_LOAD;
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With LATENCY=1 the access happens on the accepting edge, before the
    // capture registers are loaded, so the live request is used then.
    assign acc_write = (state == ST_IDLE) ? req_write : cap_write;
    assign acc_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;

    // 65-bit sum so an address near 2^64 wraps into the carry and is caught.
    assign end_addr = {1'b0, acc_addr} + 65'd7;

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_err = (end_addr >= 65'(DEPTH_BYTES)) || (acc_addr[2:0] != 3'd0);
`else
    assign addr_err = (end_addr >= 65'(DEPTH_BYTES));
`endif

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (perform && acc_write && !addr_err),
        .addr  (acc_addr[AW-1:0]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_stat  <= STAT_AOK;
        end else if (perform) begin
            if (addr_err) begin
                rsp_rdata <= '0;
                rsp_stat  <= STAT_ADR;
            end else begin
                rsp_rdata <= acc_write ? '0 : mem_rdata;
                rsp_stat  <= STAT_AOK;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_BYTES=1024, LATENCY=2).
module tb_dmem_responder;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic [2:0]  rsp_stat;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .DEPTH_BYTES (1024),
        .LATENCY     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_stat  (rsp_stat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat counts cycles from the accepting edge until
    // rsp_valid is seen (bounded at 20).
    task automatic access(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic [2:0] st, output int lat);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        st = rsp_stat;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input logic [2:0] exp_st);
        logic [63:0] rd;
        logic [2:0]  st;
        int          lat;
        access(wr, a, wd, rd, st, lat);
        check({tag, "_lat"},   64'(lat), 64'd2);
        check({tag, "_stat"},  64'(st),  64'(exp_st));
        check({tag, "_rdata"}, rd,       exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata",     rsp_rdata,      64'd0);
        check("rst_stat",      64'(rsp_stat),  64'(STAT_AOK));
        rst = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // basic store/load, boundary and wrap
        txn("st10",   1'b1, 64'h10,  64'h1122334455667788, 64'h0, STAT_AOK);
        txn("ld10",   1'b0, 64'h10,  64'h0, 64'h1122334455667788, STAT_AOK);
        txn("st18",   1'b1, 64'h18,  64'h0123456789ABCDEF, 64'h0, STAT_AOK);
        txn("st3f8",  1'b1, 64'h3F8, 64'hCAFEF00DDEADBEEF, 64'h0, STAT_AOK);
        txn("ld3f8",  1'b0, 64'h3F8, 64'h0, 64'hCAFEF00DDEADBEEF, STAT_AOK);
        txn("ld3f9",  1'b0, 64'h3F9, 64'h0, 64'h0, STAT_ADR);
        txn("st3f9",  1'b1, 64'h3F9, 64'hFFFFFFFFFFFFFFFF, 64'h0, STAT_ADR);
        txn("ld3f8b", 1'b0, 64'h3F8, 64'h0, 64'hCAFEF00DDEADBEEF, STAT_AOK);
        txn("ldwrap", 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, STAT_ADR);
        txn("ld400",  1'b0, 64'h400, 64'h0, 64'h0, STAT_ADR);

        // back-pressure: hold rsp_ready low in RESP, poke req_valid
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_rdata", rsp_rdata,      64'h1122334455667788);
            check("stall_stat",  64'(rsp_stat),  64'(STAT_AOK));
            check("stall_ready", 64'(req_ready), 64'd0);
            req_valid = (i % 2 == 0);
            req_write = 1'b1;
            req_addr  = 64'h3F9;
            req_wdata = 64'h0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("stall_end_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_done_valid", 64'(rsp_valid), 64'd0);
        check("stall_done_ready", 64'(req_ready), 64'd1);
        txn("ld10_after_stall", 1'b0, 64'h10, 64'h0, 64'h1122334455667788, STAT_AOK);

        // reset during a pending store aborts it
        txn("st20", 1'b1, 64'h20, 64'h5555666677778888, 64'h0, STAT_AOK);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_wait", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("abort_rst_valid", 64'(rsp_valid), 64'd0);
        check("abort_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_valid", 64'(rsp_valid), 64'd0);
        check("abort_rdata",    rsp_rdata,      64'h0);
        check("abort_stat",     64'(rsp_stat),  64'(STAT_AOK));
        txn("ld20", 1'b0, 64'h20, 64'h0, 64'h5555666677778888, STAT_AOK);

        // unaligned load spanning the two stored words
`ifdef DMEM_ALIGN_CHECK_EN
        txn("ld13", 1'b0, 64'h13, 64'h0, 64'h0, STAT_ADR);
`else
        txn("ld13", 1'b0, 64'h13, 64'h0, 64'hABCDEF1122334455, STAT_AOK);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
